// File: rtl/spi_host_seq.sv
// -----------------------------------------------------------------------------
// spi_host_seq
// Host-side SPI master that sequences complete command transactions towards
// the ASIC's SPI command interface, checks every response word and streams
// each received word out together with its index inside the transaction.
//
// Ports
//   CLK, NRST             system clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                0=WRREG 1=RDREG 2=STARTCONV 3=READALL 4=RESET
//   cmd_addr, cmd_wdata   register address / write data
//   rsp_valid             one-cycle pulse per received word
//   rsp_data, rsp_idx     received word and its index (held between pulses)
//   done                  one-cycle pulse at the end of a transaction
//   err                   sticky response-check error, cleared on next command
//   SPI_SCK/CS/MOSI/MISO  SPI bus (SCK idles low, CS active low, MSB first)
// -----------------------------------------------------------------------------
module spi_host_seq #(
  parameter int CLKDIV      = 4,   // SCK half-period in CLK cycles (>= 1)
  parameter int CSGAP       = 8,   // CLK cycles CS stays high after a transaction
  parameter int NUMCHANNELS = 16,  // ADC words in a burst read
  parameter int NCFGWORDS   = 5    // config words following the ADC words
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [4:0]  rsp_idx,
  output logic        done,
  output logic        err,
  output logic        SPI_SCK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int DIV_W = $clog2(2 * CLKDIV);
  localparam int GAP_W = $clog2(CSGAP + 1);

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV - 1);      // last low-phase cycle
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(2 * CLKDIV - 1);  // last high-phase cycle
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSGAP - 1);
  localparam logic [4:0]       NCH      = 5'(NUMCHANNELS);
  localparam logic [4:0]       RDALL_LAST = 5'(NUMCHANNELS + NCFGWORDS);

  localparam logic [2:0] OP_WRREG     = 3'd0;
  localparam logic [2:0] OP_RDREG     = 3'd1;
  localparam logic [2:0] OP_STARTCONV = 3'd2;
  localparam logic [2:0] OP_READALL   = 3'd3;
  localparam logic [2:0] OP_RESET     = 3'd4;

  localparam logic [15:0] RSP_ACK = 16'h3355;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  // Only word 0 of any transaction carries payload; all later words are NULL.
  function automatic logic [15:0] first_word(input logic [2:0] op,
                                             input logic [2:0] addr,
                                             input logic [7:0] wdata);
    case (op)
      OP_WRREG:     return {5'b11000, addr, wdata};
      OP_RDREG:     return {5'b00110, addr, 8'h00};
      OP_STARTCONV: return {5'b10100, 11'h000};
      OP_READALL:   return {5'b01010, 11'h000};
      OP_RESET:     return {5'b00001, 11'h000};
      default:      return 16'h0000;
    endcase
  endfunction

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_cnt, div_cnt_d;
  logic [3:0]        bit_cnt, bit_cnt_d;
  logic [4:0]        word_cnt, word_cnt_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        addr_q, addr_d;
  logic [15:0]       tx_sr, tx_sr_d;   // remaining MOSI bits of the current word
  logic [14:0]       rx_sr, rx_sr_d;   // MISO bits sampled so far in this word

  logic              sck_d, cs_d, mosi_d, ready_d;
  logic              rsp_valid_d, done_d, err_d;
  logic [15:0]       rsp_data_d;
  logic [4:0]        rsp_idx_d;

  logic [15:0]       word0;
  logic [15:0]       rx_word;
  logic [4:0]        last_idx;
  logic              rsp_bad;

  assign word0   = first_word(cmd_op, cmd_addr, cmd_wdata);
  assign rx_word = {rx_sr, SPI_MISO};

  always_comb begin
    case (op_q)
      OP_RDREG:   last_idx = 5'd1;
      OP_READALL: last_idx = RDALL_LAST;
      default:    last_idx = 5'd0;
    endcase
  end

  // Validity of the word completing on this sample, judged by its position.
  always_comb begin
    rsp_bad = 1'b0;
    if (word_cnt == 5'd0) begin
      rsp_bad = (rx_word != RSP_ACK);
    end else if (op_q == OP_RDREG) begin
      rsp_bad = (rx_word[15:11] != 5'b11000) || (rx_word[10:8] != addr_q);
    end else if (op_q == OP_READALL) begin
      if (word_cnt <= NCH)
        rsp_bad = (rx_word[15:14] != 2'b10);
      else
        rsp_bad = (rx_word[15:11] != 5'b01000) ||
                  (rx_word[10:8] != 3'(word_cnt - NCH));
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state;
    div_cnt_d   = div_cnt;
    bit_cnt_d   = bit_cnt;
    word_cnt_d  = word_cnt;
    gap_cnt_d   = gap_cnt;
    op_d        = op_q;
    addr_d      = addr_q;
    tx_sr_d     = tx_sr;
    rx_sr_d     = rx_sr;
    sck_d       = SPI_SCK;
    cs_d        = SPI_CS;
    mosi_d      = SPI_MOSI;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_idx_d   = rsp_idx;
    done_d      = 1'b0;
    err_d       = err;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          err_d      = 1'b0;
          div_cnt_d  = '0;
          bit_cnt_d  = 4'd0;
          word_cnt_d = 5'd0;
          gap_cnt_d  = '0;
          if (cmd_op > OP_RESET) begin
            // Invalid op: no bus activity, report and back off straight away.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_GAP;
          end else begin
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            mosi_d  = word0[15];
            tx_sr_d = {word0[14:0], 1'b0};
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        if (div_cnt == DIV_HALF) begin
          div_cnt_d = '0;
          state_d   = S_SHIFT;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        if (div_cnt == DIV_HALF) begin
          // Rising SCK edge: sample MISO, publish the word on its 16th bit.
          sck_d     = 1'b1;
          rx_sr_d   = rx_word[14:0];
          div_cnt_d = div_cnt + 1'b1;
          if (bit_cnt == 4'd15) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_word;
            rsp_idx_d   = word_cnt;
            if (rsp_bad) err_d = 1'b1;
          end
        end else if (div_cnt == DIV_FULL) begin
          // Falling SCK edge: present the next MOSI bit.
          sck_d     = 1'b0;
          div_cnt_d = '0;
          if (bit_cnt == 4'd15) begin
            bit_cnt_d = 4'd0;
            mosi_d    = 1'b0;
            tx_sr_d   = 16'h0000;
            if (word_cnt == last_idx)
              state_d = S_HOLD;
            else
              word_cnt_d = word_cnt + 5'd1;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
            mosi_d    = tx_sr[15];
            tx_sr_d   = {tx_sr[14:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end

      S_HOLD: begin
        if (div_cnt == DIV_HALF) begin
          cs_d      = 1'b1;
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST)
          state_d = S_IDLE;
        else
          gap_cnt_d = gap_cnt + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!NRST) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= 4'd0;
      word_cnt  <= 5'd0;
      gap_cnt   <= '0;
      op_q      <= 3'd0;
      addr_q    <= 3'd0;
      tx_sr     <= 16'h0000;
      rx_sr     <= 15'h0000;
      SPI_SCK   <= 1'b0;
      SPI_CS    <= 1'b1;
      SPI_MOSI  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_idx   <= 5'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_cnt_d;
      bit_cnt   <= bit_cnt_d;
      word_cnt  <= word_cnt_d;
      gap_cnt   <= gap_cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      tx_sr     <= tx_sr_d;
      rx_sr     <= rx_sr_d;
      SPI_SCK   <= sck_d;
      SPI_CS    <= cs_d;
      SPI_MOSI  <= mosi_d;
      cmd_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_idx   <= rsp_idx_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_host_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_host_seq
// Self-checking bench for spi_host_seq. A cycle-level SPI slave answers with a
// prepared list of response words and collects the MOSI words; directed and
// randomized transactions are compared against a word-list reference model.
// -----------------------------------------------------------------------------
module tb_spi_host_seq;

  localparam int D    = 2;
  localparam int GAP  = 8;
  localparam int NCH  = 16;
  localparam int NCFG = 5;

  localparam logic [2:0] OP_WRREG     = 3'd0;
  localparam logic [2:0] OP_RDREG     = 3'd1;
  localparam logic [2:0] OP_STARTCONV = 3'd2;
  localparam logic [2:0] OP_READALL   = 3'd3;
  localparam logic [2:0] OP_RESET     = 3'd4;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_idx;
  logic        done;
  logic        err;
  logic        SPI_SCK;
  logic        SPI_CS;
  logic        SPI_MOSI;
  logic        SPI_MISO = 1'b0;

  spi_host_seq #(
    .CLKDIV(D), .CSGAP(GAP), .NUMCHANNELS(NCH), .NCFGWORDS(NCFG)
  ) dut (
    .CLK(CLK), .NRST(NRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_idx(rsp_idx),
    .done(done), .err(err),
    .SPI_SCK(SPI_SCK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // SPI slave + monitors (sample on the falling CLK edge)
  // ---------------------------------------------------------------------------
  logic [15:0] tb_resp[$];   // words the slave returns, in order
  logic [15:0] mon_mosi[$];  // words captured from MOSI
  logic [20:0] mon_rsp[$];   // {rsp_idx, rsp_data} per rsp_valid pulse
  int          cs_cnt = 0, cs_low_len = 0;
  int          sl_word = 0, sl_bit = 0, mo_bits = 0, sck_rises = 0;
  int          rsp_timing_bad = 0, done_cnt = 0;
  logic [15:0] mo_sr = 16'h0;
  logic        cs_prev = 1'b1, sck_prev = 1'b0;

  always @(negedge CLK) begin
    logic [15:0] cur;
    if (!SPI_CS && cs_prev) begin
      cs_cnt = 0; sl_word = 0; sl_bit = 0; mo_bits = 0; sck_rises = 0;
      mon_mosi.delete();
      mon_rsp.delete();
    end
    if (!SPI_CS) begin
      cs_cnt++;
      if (SPI_SCK && !sck_prev) begin
        sck_rises++;
        mo_sr = {mo_sr[14:0], SPI_MOSI};
        mo_bits++;
        if (mo_bits == 16) begin
          mon_mosi.push_back(mo_sr);
          mo_bits = 0;
        end
      end
      if (!SPI_SCK && sck_prev) begin
        sl_bit++;
        if (sl_bit == 16) begin
          sl_bit = 0;
          sl_word++;
        end
      end
    end else if (!cs_prev) begin
      cs_low_len = cs_cnt;
    end
    if (rsp_valid) begin
      mon_rsp.push_back({rsp_idx, rsp_data});
      // The word must appear in the cycle right after the SCK rising edge.
      if (!(SPI_SCK && !sck_prev)) rsp_timing_bad++;
    end
    if (done) done_cnt++;
    cur = (sl_word < tb_resp.size()) ? tb_resp[sl_word] : 16'h0000;
    SPI_MISO = cur[15 - sl_bit];
    cs_prev  = SPI_CS;
    sck_prev = SPI_SCK;
  end

  // ---------------------------------------------------------------------------
  // Reference model: word lists and response rules
  // ---------------------------------------------------------------------------
  function automatic int model_nwords(input logic [2:0] op);
    case (op)
      OP_RDREG:   return 2;
      OP_READALL: return 1 + NCH + NCFG;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [15:0] model_tx(input logic [2:0] op, input logic [2:0] addr,
                                           input logic [7:0] wdata, input int i);
    if (i != 0) return 16'h0000;
    case (op)
      OP_WRREG:     return {5'b11000, addr, wdata};
      OP_RDREG:     return {5'b00110, addr, 8'h00};
      OP_STARTCONV: return 16'hA000;
      OP_READALL:   return 16'h5000;
      default:      return 16'h0800;
    endcase
  endfunction

  function automatic logic model_err(input logic [2:0] op, input logic [2:0] addr);
    logic        bad;
    logic [15:0] w;
    bad = 1'b0;
    for (int i = 0; i < model_nwords(op); i++) begin
      w = (i < tb_resp.size()) ? tb_resp[i] : 16'h0000;
      if (i == 0)
        bad |= (w != 16'h3355);
      else if (op == OP_RDREG)
        bad |= (w[15:11] != 5'b11000) || (w[10:8] != addr);
      else if (op == OP_READALL) begin
        if (i <= NCH) bad |= (w[15:14] != 2'b10);
        else          bad |= (w[15:11] != 5'b01000) || (w[10:8] != 3'(i - NCH));
      end
    end
    return bad;
  endfunction

  task automatic build_readall(input int bad_idx, input logic [15:0] bad_val);
    tb_resp.delete();
    tb_resp.push_back(16'h3355);
    for (int ch = 0; ch < NCH; ch++) tb_resp.push_back(16'h8000 | 16'(ch));
    for (int k = 1; k <= NCFG; k++) tb_resp.push_back({5'b01000, 3'(k), 8'(8'h10 + k)});
    if (bad_idx >= 0) tb_resp[bad_idx] = bad_val;
  endtask

  // ---------------------------------------------------------------------------
  // Transaction helpers
  // ---------------------------------------------------------------------------
  task automatic start_cmd(input logic [2:0] op, input logic [2:0] addr,
                           input logic [7:0] wdata, input string tag);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    check({tag, "/accept"}, 32'(cmd_ready), 32'd1);
    tick();
    // Keep requesting junk while busy: it must be neither latched nor queued.
    cmd_op = 3'($urandom); cmd_addr = 3'($urandom); cmd_wdata = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] addr,
                         input logic [7:0] wdata, input string tag);
    int   n, busy_rdy, nw;
    logic exp_err;
    nw      = model_nwords(op);
    exp_err = model_err(op, addr);
    start_cmd(op, addr, wdata, tag);
    check({tag, "/err_clr"}, 32'(err), 32'd0);
    n = 0; busy_rdy = 0;
    while (!done && n < 4000) begin
      if (cmd_ready) busy_rdy++;
      tick(); n++;
    end
    check({tag, "/done"}, 32'(done), 32'd1);
    cmd_valid = 1'b0;
    check({tag, "/busy_ready"}, 32'(busy_rdy), 32'd0);
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    check({tag, "/cs_at_done"}, 32'(SPI_CS), 32'd1);
    check({tag, "/cs_low_len"}, 32'(cs_low_len), 32'(2 * D + 32 * D * nw));
    check({tag, "/n_mosi"}, 32'(mon_mosi.size()), 32'(nw));
    for (int i = 0; i < nw && i < mon_mosi.size(); i++)
      check($sformatf("%s/mosi%0d", tag, i), 32'(mon_mosi[i]), 32'(model_tx(op, addr, wdata, i)));
    check({tag, "/n_rsp"}, 32'(mon_rsp.size()), 32'(nw));
    for (int i = 0; i < nw && i < mon_rsp.size(); i++)
      check($sformatf("%s/rsp%0d", tag, i), 32'(mon_rsp[i]), 32'({5'(i), tb_resp[i]}));
    check({tag, "/rsp_timing"}, 32'(rsp_timing_bad), 32'd0);
    tick();
    check({tag, "/done_1cyc"}, 32'(done), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          n, cs_bad, d0, sel;
    logic [2:0]  op, addr;
    logic [7:0]  wdata;

    NRST = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 3'd0; cmd_wdata = 8'd0;
    repeat (3) tick();
    check("rst/cs",        32'(SPI_CS),    32'd1);
    check("rst/sck",       32'(SPI_SCK),   32'd0);
    check("rst/mosi",      32'(SPI_MOSI),  32'd0);
    check("rst/ready",     32'(cmd_ready), 32'd0);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/rsp_data",  32'(rsp_data),  32'd0);
    check("rst/rsp_idx",   32'(rsp_idx),   32'd0);
    check("rst/done",      32'(done),      32'd0);
    check("rst/err",       32'(err),       32'd0);
    NRST = 1'b1;
    tick();
    check("rst/ready_rise", 32'(cmd_ready), 32'd1);

    // WRREG addr 3, data A5
    tb_resp = '{16'h3355};
    run_cmd(OP_WRREG, 3'd3, 8'hA5, "wrreg");

    // RDREG addr 5, good and bad readback
    tb_resp = '{16'h3355, 16'hC57E};
    run_cmd(OP_RDREG, 3'd5, 8'h00, "rdreg_ok");
    tb_resp = '{16'h3355, 16'hC47E};
    run_cmd(OP_RDREG, 3'd5, 8'h00, "rdreg_bad");

    // READALL, clean and with one corrupted channel word
    build_readall(-1, 16'h0);
    run_cmd(OP_READALL, 3'd0, 8'h00, "readall_ok");
    build_readall(7, 16'h4007);
    run_cmd(OP_READALL, 3'd0, 8'h00, "readall_bad");

    // STARTCONV with a bad ACK; err stays set until the next command
    tb_resp = '{16'hABCD};
    run_cmd(OP_STARTCONV, 3'd0, 8'h00, "startconv");
    repeat (3) tick();
    check("startconv/err_sticky", 32'(err), 32'd1);
    tb_resp = '{16'h3355};
    run_cmd(OP_RESET, 3'd0, 8'h00, "reset_cmd");

    // Invalid op followed by WRREG with cmd_valid held high throughout
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_addr = 3'd0; cmd_wdata = 8'd0;
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    tick();
    check("inval/done",  32'(done),      32'd1);
    check("inval/err",   32'(err),       32'd1);
    check("inval/ready", 32'(cmd_ready), 32'd0);
    cmd_op = OP_WRREG; cmd_addr = 3'd6; cmd_wdata = 8'h3C;
    n = 0; cs_bad = 0;
    while (!cmd_ready && n < 100) begin
      if (!SPI_CS || SPI_SCK) cs_bad++;
      n++; tick();
    end
    check("inval/gap_len",  32'(n),             32'(GAP));
    check("inval/no_bus",   32'(cs_bad),        32'd0);
    check("inval/n_done",   32'(done_cnt - d0), 32'd1);
    tb_resp = '{16'h3355};
    run_cmd(OP_WRREG, 3'd6, 8'h3C, "after_inval");

    // Reset during bit 7 of word 3 of a READALL
    build_readall(-1, 16'h0);
    start_cmd(OP_READALL, 3'd0, 8'h00, "rst_mid");
    n = 0;
    while (sck_rises < 3 * 16 + 8 && n < 4000) begin tick(); n++; end
    check("rst_mid/reached", 32'(sck_rises), 32'(3 * 16 + 8));
    check("rst_mid/n_rsp",   32'(mon_rsp.size()), 32'd3);
    d0 = done_cnt;
    cmd_valid = 1'b0;
    NRST = 1'b0;
    tick();
    check("rst_mid/cs",    32'(SPI_CS),    32'd1);
    check("rst_mid/sck",   32'(SPI_SCK),   32'd0);
    check("rst_mid/done",  32'(done),      32'd0);
    check("rst_mid/ready", 32'(cmd_ready), 32'd0);
    repeat (2) tick();
    NRST = 1'b1;
    tick();
    check("rst_mid/ready_rise", 32'(cmd_ready), 32'd1);
    repeat (3) tick();
    check("rst_mid/no_done", 32'(done_cnt - d0), 32'd0);

    // Randomized transactions
    for (int t = 0; t < 10; t++) begin
      sel   = int'($urandom_range(0, 4));
      op    = (sel == 3) ? OP_RESET : (sel == 4) ? OP_READALL : 3'(sel);
      addr  = 3'($urandom);
      wdata = 8'($urandom);
      if (op == OP_READALL) begin
        if ($urandom_range(0, 1) == 0) build_readall(-1, 16'h0);
        else build_readall(int'($urandom_range(0, NCH + NCFG)), 16'($urandom));
      end else begin
        tb_resp.delete();
        tb_resp.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h3355);
        if (op == OP_RDREG)
          tb_resp.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                        : {5'b11000, addr, 8'($urandom)});
      end
      run_cmd(op, addr, wdata, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
